// File: rtl/ddos_drop_gate_pkg.sv
// Shared DDoS gate definitions: decision bit positions, IOQ header marker,
// FSM state encoding and the decision decode helper.
package ddos_drop_gate_pkg;

  localparam int DEC_DROP_BIT = 0;
  localparam int DEC_ARP_BIT  = 1;

  localparam logic [7:0] IOQ_CTRL = 8'hFF;

  typedef enum logic [2:0] {
    WAIT_DEC     = 3'd0,
    FWD_HDR      = 3'd1,
    FWD_PAYLOAD  = 3'd2,
    DROP_HDR     = 3'd3,
    DROP_PAYLOAD = 3'd4
  } gate_state_t;

  // ARP bypass wins over the drop bit.
  function automatic logic dec_is_drop(input logic [1:0] dec);
    return dec[DEC_DROP_BIT] & ~dec[DEC_ARP_BIT];
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head word is visible on dout while
// the FIFO is non-empty; rd_en pops it. A write on a full FIFO is accepted
// only when a pop happens in the same cycle.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_FULL = DEPTH[MAX_DEPTH_BITS:0];
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_NF   = DEPTH_FULL - 1'b1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
  logic [MAX_DEPTH_BITS:0]   count_q;
  logic                      do_wr;
  logic                      do_rd;
  logic                      full;

  assign full        = (count_q == DEPTH_FULL);
  assign empty       = (count_q == '0);
  assign nearly_full = (count_q >= DEPTH_NF);
  assign do_rd       = rd_en & ~empty;
  assign do_wr       = wr_en & (~full | do_rd);
  assign dout        = mem[rd_ptr_q];

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddos_drop_gate.sv
// DDoS drop gate: pairs each buffered packet's IOQ header with one decision
// from the decision FIFO, then either forwards the packet downstream or
// drains it silently. Stray words outside a packet are discarded and counted.
module ddos_drop_gate
  import ddos_drop_gate_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int IN_FIFO_DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [1:0]            dec_fifo_dout,
  input  logic                  dec_fifo_empty,
  output logic                  dec_fifo_rd_en,
  output logic [31:0]           pkt_fwd_cnt,
  output logic [31:0]           pkt_drop_cnt,
  output logic [31:0]           misalign_cnt
);

  localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [CTRL_WIDTH-1:0] HDR_CTRL = CTRL_WIDTH'(IOQ_CTRL);

  gate_state_t           state_q, state_d;
  logic [WORD_WIDTH-1:0] head_word;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  buf_empty;
  logic                  buf_nearly_full;
  logic                  pop;
  logic                  fwd_pop;
  logic                  fwd_eop;
  logic                  drop_eop;
  logic                  stray;
  logic                  dec_rd;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;
  logic                  out_wr_q;
  logic [31:0]           fwd_cnt_q, drop_cnt_q, mis_cnt_q;

  assign in_rdy    = ~buf_nearly_full;
  assign head_data = head_word[DATA_WIDTH-1:0];
  assign head_ctrl = head_word[DATA_WIDTH +: CTRL_WIDTH];

  fallthrough_small_fifo #(
    .WIDTH          (WORD_WIDTH),
    .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr & in_rdy),
    .rd_en       (pop),
    .dout        (head_word),
    .nearly_full (buf_nearly_full),
    .empty       (buf_empty)
  );

  // Next-state, pop and decision-read decode for the packet walker.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    fwd_pop  = 1'b0;
    fwd_eop  = 1'b0;
    drop_eop = 1'b0;
    stray    = 1'b0;
    dec_rd   = 1'b0;
    case (state_q)
      WAIT_DEC: begin
        if (!buf_empty) begin
          if (head_ctrl == HDR_CTRL) begin
            // Decision cycle: read the verdict but leave the header in place.
            if (!dec_fifo_empty) begin
              dec_rd  = 1'b1;
              state_d = dec_is_drop(dec_fifo_dout) ? DROP_HDR : FWD_HDR;
            end
          end else begin
            pop   = 1'b1;
            stray = 1'b1;
          end
        end
      end
      FWD_HDR, FWD_PAYLOAD: begin
        if (!buf_empty && out_rdy) begin
          pop     = 1'b1;
          fwd_pop = 1'b1;
          if (state_q == FWD_HDR && head_ctrl == '0) begin
            state_d = FWD_PAYLOAD;
          end else if (state_q == FWD_PAYLOAD && head_ctrl != '0) begin
            fwd_eop = 1'b1;
            state_d = WAIT_DEC;
          end
        end
      end
      DROP_HDR, DROP_PAYLOAD: begin
        if (!buf_empty) begin
          pop = 1'b1;
          if (state_q == DROP_HDR && head_ctrl == '0) begin
            state_d = DROP_PAYLOAD;
          end else if (state_q == DROP_PAYLOAD && head_ctrl != '0) begin
            drop_eop = 1'b1;
            state_d  = WAIT_DEC;
          end
        end
      end
      default: state_d = WAIT_DEC;
    endcase
  end

  // State register and registered downstream bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_DEC;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      state_q  <= state_d;
      out_wr_q <= fwd_pop;
      if (fwd_pop) begin
        out_data_q <= head_data;
        out_ctrl_q <= head_ctrl;
      end
    end
  end

  // Packet and stray-word statistics, free-running modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
      mis_cnt_q  <= '0;
    end else begin
      if (fwd_eop)  fwd_cnt_q  <= fwd_cnt_q + 32'd1;
      if (drop_eop) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (stray)    mis_cnt_q  <= mis_cnt_q + 32'd1;
    end
  end

  assign out_data       = out_data_q;
  assign out_ctrl       = out_ctrl_q;
  assign out_wr         = out_wr_q;
  assign dec_fifo_rd_en = dec_rd;
  assign pkt_fwd_cnt    = fwd_cnt_q;
  assign pkt_drop_cnt   = drop_cnt_q;
  assign misalign_cnt   = mis_cnt_q;

endmodule

// File: tb/tb_ddos_drop_gate.sv
// Directed bench for ddos_drop_gate: a table of packet scenarios plus a
// hand-written reset-mid-packet sequence. The decision FIFO and the input
// source are modelled with queues; outputs are sampled on the falling edge.
module tb_ddos_drop_gate;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic [1:0]  dec_fifo_dout = '0;
  logic        dec_fifo_empty = 1'b1;
  logic        dec_fifo_rd_en;
  logic [31:0] pkt_fwd_cnt, pkt_drop_cnt, misalign_cnt;

  ddos_drop_gate dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_ctrl        (in_ctrl),
    .in_wr          (in_wr),
    .in_rdy         (in_rdy),
    .out_data       (out_data),
    .out_ctrl       (out_ctrl),
    .out_wr         (out_wr),
    .out_rdy        (out_rdy),
    .dec_fifo_dout  (dec_fifo_dout),
    .dec_fifo_empty (dec_fifo_empty),
    .dec_fifo_rd_en (dec_fifo_rd_en),
    .pkt_fwd_cnt    (pkt_fwd_cnt),
    .pkt_drop_cnt   (pkt_drop_cnt),
    .misalign_cnt   (misalign_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [71:0] in_q[$];
  logic [1:0]  dec_q[$];
  logic [71:0] out_log[$];
  int          rdy_mode = 0;  // 0: always ready, 1: never ready, 2: toggle
  bit          rd_seen = 0;
  int          cyc = 0;
  int          rd_pulses = 0;
  int          rd_cyc = -1;
  int          first_out_cyc = -1;
  int          drop_cyc = -1;

  typedef struct {
    string      name;
    logic [1:0] dec;
    int         rdy_mode;
    int         pre_wait;
    bit         stray;
    int         exp_fwd;
    int         exp_drop;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk_word(input int tag, input int j);
    logic [7:0] c;
    if (j == 0)      c = 8'hFF;
    else if (j == 4) c = 8'h04;
    else             c = 8'h00;
    return {c, 16'hA5A5, 16'(tag), 32'(j)};
  endfunction

  task automatic clear_logs();
    out_log.delete();
    rd_pulses     = 0;
    rd_cyc        = -1;
    first_out_cyc = -1;
    drop_cyc      = -1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    in_q.delete();
    dec_q.delete();
    rd_seen = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    clear_logs();
  endtask

  // Input source and decision FIFO model, updated just after each rising edge.
  initial begin
    logic [1:0] dtmp;
    logic [71:0] wtmp;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen) begin
        if (dec_q.size() > 0) dtmp = dec_q.pop_front();
        rd_seen = 0;
      end
      if (in_q.size() > 0 && in_rdy && !reset) begin
        wtmp = in_q.pop_front();
        in_wr = 1'b1;
        {in_ctrl, in_data} = wtmp;
      end else begin
        in_wr = 1'b0;
      end
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'b0;
        default: out_rdy = ~out_rdy;
      endcase
      dec_fifo_empty = (dec_q.size() == 0);
      dec_fifo_dout  = (dec_q.size() > 0) ? dec_q[0] : 2'b00;
    end
  end

  // Output monitor on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (out_wr) begin
          out_log.push_back({out_ctrl, out_data});
          if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        if (dec_fifo_rd_en) begin
          rd_pulses++;
          rd_cyc  = cyc;
          rd_seen = 1;
        end
        if (pkt_drop_cnt != 0 && drop_cyc < 0) drop_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    vecs[0] = '{"forward",      2'b00, 0,  8, 1'b0, 1, 0};
    vecs[1] = '{"drop_norady",  2'b01, 1,  8, 1'b0, 0, 1};
    vecs[2] = '{"arp_override", 2'b11, 0,  8, 1'b0, 1, 0};
    vecs[3] = '{"starvation",   2'b00, 0, 20, 1'b0, 1, 0};
    vecs[4] = '{"arp_only",     2'b10, 0,  8, 1'b0, 1, 0};
    vecs[5] = '{"stray_toggle", 2'b00, 2,  8, 1'b1, 1, 0};

    // Reset state while reset is held.
    #1;
    chk("rst_out_wr",   out_wr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_rd_en",    dec_fifo_rd_en, 0);
    chk("rst_fwd_cnt",  pkt_fwd_cnt, 0);
    chk("rst_drop_cnt", pkt_drop_cnt, 0);
    chk("rst_mis_cnt",  misalign_cnt, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("rst_in_rdy", in_rdy, 1);

    for (int i = 0; i < 6; i++) begin
      rdy_mode = vecs[i].rdy_mode;
      do_reset();
      if (vecs[i].stray) in_q.push_back({8'h00, 64'hDEAD_BEEF_0000_0001});
      for (int j = 0; j < 5; j++) in_q.push_back(mk_word(i, j));
      repeat (vecs[i].pre_wait) @(posedge clk);
      chk({vecs[i].name, "_idle_out"}, out_log.size(), 0);
      chk({vecs[i].name, "_idle_rd"}, rd_pulses, 0);
      dec_q.push_back(vecs[i].dec);
      done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
        @(posedge clk);
        if (pkt_fwd_cnt != 0 || pkt_drop_cnt != 0) done = 1;
      end
      chk({vecs[i].name, "_timeout"}, done, 1);
      repeat (3) @(posedge clk);
      chk({vecs[i].name, "_fwd_cnt"}, pkt_fwd_cnt, vecs[i].exp_fwd);
      chk({vecs[i].name, "_drop_cnt"}, pkt_drop_cnt, vecs[i].exp_drop);
      chk({vecs[i].name, "_rd_pulses"}, rd_pulses, 1);
      chk({vecs[i].name, "_mis_cnt"}, misalign_cnt, vecs[i].stray ? 1 : 0);
      chk({vecs[i].name, "_words"}, out_log.size(), vecs[i].exp_fwd ? 5 : 0);
      if (vecs[i].exp_fwd != 0 && out_log.size() == 5) begin
        for (int j = 0; j < 5; j++) chk({vecs[i].name, "_word"}, out_log[j], mk_word(i, j));
      end
      if (vecs[i].exp_fwd != 0 && vecs[i].rdy_mode == 0)
        chk({vecs[i].name, "_fwd_latency"}, first_out_cyc - rd_cyc, 2);
      if (vecs[i].exp_drop != 0)
        chk({vecs[i].name, "_drain_cycles"}, drop_cyc - rd_cyc, 6);
      $display("vector %0d %s dec=%b fwd=%0d drop=%0d mis=%0d words=%0d",
               i, vecs[i].name, vecs[i].dec, pkt_fwd_cnt, pkt_drop_cnt, misalign_cnt, out_log.size());
    end

    // Reset in the middle of a forwarded packet, then a fresh packet.
    rdy_mode = 0;
    do_reset();
    dec_q.push_back(2'b00);
    dec_q.push_back(2'b01);
    for (int j = 0; j < 5; j++) in_q.push_back(mk_word(10, j));
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      if (out_log.size() >= 3) done = 1;
    end
    chk("midrst_reach_payload2", done, 1);
    #3 reset = 1'b1;
    in_q.delete();
    #1;
    chk("midrst_out_wr",   out_wr, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_fwd_cnt",  pkt_fwd_cnt, 0);
    chk("midrst_drop_cnt", pkt_drop_cnt, 0);
    chk("midrst_mis_cnt",  misalign_cnt, 0);
    chk("midrst_dec_left", dec_q.size(), 1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    clear_logs();
    #1 chk("midrst_in_rdy", in_rdy, 1);
    for (int j = 0; j < 5; j++) in_q.push_back(mk_word(11, j));
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      if (pkt_fwd_cnt != 0 || pkt_drop_cnt != 0) done = 1;
    end
    chk("midrst_next_timeout", done, 1);
    repeat (3) @(posedge clk);
    chk("midrst_next_drop", pkt_drop_cnt, 1);
    chk("midrst_next_fwd",  pkt_fwd_cnt, 0);
    chk("midrst_next_words", out_log.size(), 0);
    chk("midrst_next_rd",   rd_pulses, 1);
    $display("reset-mid-packet: fwd=%0d drop=%0d words=%0d", pkt_fwd_cnt, pkt_drop_cnt, out_log.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddos_drop_gate.md
DDOS_DROP_GATE -- requirements
Module: ddos_drop_gate

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the packet data bus width.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, meaning the packet ctrl bus width.
REQ-003 The block SHALL have parameter IN_FIFO_DEPTH_BITS, default 3, meaning the log2 depth of the input word buffer.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have ports in_data (input, DATA_WIDTH), in_ctrl (input, CTRL_WIDTH), in_wr (input, 1) and in_rdy (output, 1), forming the upstream packet bus.
REQ-007 The block SHALL have ports out_data (output, DATA_WIDTH), out_ctrl (output, CTRL_WIDTH), out_wr (output, 1) and out_rdy (input, 1), forming the downstream packet bus.
REQ-008 The block SHALL have ports dec_fifo_dout (input, 2), dec_fifo_empty (input, 1) and dec_fifo_rd_en (output, 1) to read the first-word-fall-through DDoS decision FIFO.
REQ-009 The block SHALL have ports pkt_fwd_cnt, pkt_drop_cnt and misalign_cnt, each output, 32 bits, holding the forwarded-packet, dropped-packet and stray-word counts.

Function
REQ-010 The decision encoding SHALL be: bit0 = drop, bit1 = ARP bypass; bit1=1 forces forward regardless of bit0.
REQ-011 Input words SHALL be written into the input buffer when in_wr=1; in_rdy SHALL be the buffer's not-nearly-full, with at least one free slot of margin.
REQ-012 The state machine SHALL have the states WAIT_DEC, FWD_HDR, FWD_PAYLOAD, DROP_HDR and DROP_PAYLOAD.
REQ-013 In WAIT_DEC with a buffer head word whose ctrl is 8'hFF (IOQ header) and dec_fifo_empty=0, the block SHALL pulse dec_fifo_rd_en for exactly 1 cycle and sample dec_fifo_dout in that same cycle.
REQ-014 From WAIT_DEC, the block SHALL go to FWD_HDR when the decision is forward and to DROP_HDR when it is drop; no data word SHALL be consumed in the decision cycle.
REQ-015 In WAIT_DEC with an IOQ head word and dec_fifo_empty=1, the block SHALL stall with no reads, no output and no timeout.
REQ-016 In WAIT_DEC with a head word whose ctrl is not 8'hFF, the block SHALL pop and discard that word, increment misalign_cnt, and leave the decision FIFO untouched.
REQ-017 In FWD_HDR/FWD_PAYLOAD, one word SHALL be popped per cycle only when the buffer is non-empty and out_rdy=1; the popped word SHALL appear on out_data/out_ctrl with out_wr=1 on the next cycle (registered, 1-cycle latency).
REQ-018 The HDR state SHALL move to its PAYLOAD state on the first popped word with ctrl==0; the PAYLOAD state SHALL return to WAIT_DEC on the first popped word with ctrl!=0 (EOP), and that EOP word SHALL be forwarded or dropped as well.
REQ-019 In DROP_HDR/DROP_PAYLOAD, one word SHALL be popped per cycle whenever the buffer is non-empty, independent of out_rdy, and out_wr SHALL remain 0.
REQ-020 pkt_fwd_cnt and pkt_drop_cnt SHALL increment by 1 in the cycle the EOP word of a forwarded or dropped packet is popped.
REQ-021 All three counters SHALL wrap modulo 2^32.
REQ-022 A back-to-back packet SHALL reach WAIT_DEC on the cycle after EOP, so the minimum inter-packet bubble is 1 cycle (the decision cycle).
REQ-023 Simultaneous in_wr and pop on a full buffer SHALL be legal; an in_wr while in_rdy=0 is a protocol violation and the word SHALL be discarded.

Reset
REQ-024 When reset is asserted, the block SHALL asynchronously force: state=WAIT_DEC; out_wr=0; out_data=0; out_ctrl=0; dec_fifo_rd_en=0; all counters=0; input buffer empty; in_rdy=1 from the first cycle after deassertion.
REQ-025 Reset during a packet SHALL abandon the packet and consume no decision; the first IOQ word after reset SHALL be paired with the current decision FIFO head.

Structure
REQ-026 The decision bit positions (DEC_DROP_BIT=0, DEC_ARP_BIT=1), IOQ_CTRL=8'hFF and the state encodings SHALL live in a shared ddos package/include, alongside the existing ddos defines.
REQ-027 The input buffer SHALL be the one sub-module, fallthrough_small_fifo with WIDTH=DATA_WIDTH+CTRL_WIDTH and MAX_DEPTH_BITS=IN_FIFO_DEPTH_BITS; the FSM and counters SHALL be in the top level.

Verification
REQ-028 The bench SHALL cover forward: decision 2'b00; packet FF hdr, 3 payload words, EOP ctrl=8'h04 -> 5 words out in order, pkt_fwd_cnt=1, one rd_en pulse.
REQ-029 The bench SHALL cover drop: decision 2'b01, same packet with out_rdy=0 throughout -> out_wr never asserts, 5 words drained in 5 cycles, pkt_drop_cnt=1.
REQ-030 The bench SHALL cover ARP override: decision 2'b11 -> packet forwarded, pkt_fwd_cnt=1, pkt_drop_cnt=0.
REQ-031 The bench SHALL cover decision starvation: packet buffered while dec_fifo_empty=1 for 20 cycles -> no output and no rd_en; decision 2'b00 arriving -> forwarding starts 2 cycles after rd_en.
REQ-032 The bench SHALL cover a stray word plus backpressure: word with ctrl=8'h00 in WAIT_DEC -> misalign_cnt=1; then a forward packet with out_rdy toggling every cycle -> no duplicated or lost words.
REQ-033 The bench SHALL cover reset mid-packet: reset asserted on payload word 2 -> out_wr=0 immediately, all counters=0, and the next packet is handled with the next decision.
